// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad-lock support controller.
package lock_pkg;

  typedef enum logic [1:0] {P_IDLE, P_RUN, P_DONE}     pen_state_t;
  typedef enum logic [1:0] {R_LOCKED, R_OPEN, R_PULSE} rel_state_t;

  // Counter width for a modulus n; never collapses to zero bits when n == 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_down_timer.sv
// Tick-driven interval timer: start (re)loads zero, expired pulses on the final tick.
module lock_down_timer
  import lock_pkg::*;
#(
  parameter int TICKS = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic running,
  output logic expired
);

  localparam int CW = cw(TICKS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    expired = run_q && tick && (cnt_q == CW'(TICKS-1));
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (expired) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q && tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign running = run_q;

endmodule

// File: rtl/lock_support_ctrl.sv
// Error counter, penalty timer and relock timer serving the keypad-lock FSM.
module lock_support_ctrl
  import lock_pkg::*;
#(
  parameter int TICK_DIV      = 1000,
  parameter int MAX_ERR       = 3,
  parameter int PENALTY_TICKS = 5000,
  parameter int RELOCK_TICKS  = 3000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         CLRCNTR,
  input  logic                         INC,
  input  logic                         CLRTIMER,
  input  logic                         UNLOCK,
  input  logic                         lock_req,
  output logic                         ECNT3,
  output logic                         WAITDONE,
  output logic                         LOCKED,
  output logic                         bolt_open,
  output logic                         penalty_active,
  output logic [$clog2(MAX_ERR+1)-1:0] err_count
);

  localparam int EW = $clog2(MAX_ERR+1);
  localparam int PW = cw(TICK_DIV);

  logic [PW-1:0] pre_q, pre_d;
  logic [EW-1:0] err_q, err_d;
  pen_state_t    pen_q, pen_d;
  rel_state_t    rel_q, rel_d;
  logic          tick;
  logic          pen_running, pen_expired;
  logic          rel_start, rel_expired;
  logic          unused_rel_running;

  // Free-running prescaler; timer starts never realign it.
  always_comb begin
    tick  = (pre_q == PW'(TICK_DIV-1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (CLRCNTR)                              err_d = '0;
    else if (INC && err_q != EW'(MAX_ERR))    err_d = err_q + 1'b1;
  end

  lock_down_timer #(.TICKS(PENALTY_TICKS)) u_pen_tmr (
    .clk     (clk),
    .rst     (rst),
    .start   (CLRTIMER),
    .tick    (tick),
    .running (pen_running),
    .expired (pen_expired)
  );

  // A relock timer left running by a manual lock is harmless: its expiry is
  // ignored outside R_OPEN and the next UNLOCK reloads it.
  assign rel_start = UNLOCK && (rel_q != R_PULSE);

  lock_down_timer #(.TICKS(RELOCK_TICKS)) u_rel_tmr (
    .clk     (clk),
    .rst     (rst),
    .start   (rel_start),
    .tick    (tick),
    .running (unused_rel_running),
    .expired (rel_expired)
  );

  always_comb begin
    pen_d = pen_q;
    if (CLRTIMER) begin
      pen_d = P_RUN;
    end else begin
      case (pen_q)
        P_IDLE:  pen_d = P_IDLE;
        P_RUN:   if (pen_expired) pen_d = P_DONE;
        P_DONE:  pen_d = P_DONE;
        default: pen_d = P_IDLE;
      endcase
    end
  end

  always_comb begin
    rel_d = rel_q;
    case (rel_q)
      R_LOCKED: if (UNLOCK) rel_d = R_OPEN;
      R_OPEN: begin
        if (UNLOCK)                       rel_d = R_OPEN;
        else if (lock_req || rel_expired) rel_d = R_PULSE;
      end
      R_PULSE:  rel_d = R_LOCKED;
      default:  rel_d = R_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      err_q <= '0;
      pen_q <= P_IDLE;
      rel_q <= R_LOCKED;
    end else begin
      pre_q <= pre_d;
      err_q <= err_d;
      pen_q <= pen_d;
      rel_q <= rel_d;
    end
  end

  assign err_count      = err_q;
  assign ECNT3          = (err_q == EW'(MAX_ERR));
  assign WAITDONE       = (pen_q == P_DONE);
  assign penalty_active = pen_running;
  assign LOCKED         = (rel_q == R_PULSE);
  assign bolt_open      = (rel_q == R_OPEN);

endmodule

// File: tb/tb_lock_support_ctrl.sv
// Randomised and directed bench for lock_support_ctrl against a remaining-ticks model.
module tb_lock_support_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clrcntr, inc, clrtimer, unlock, lock_req;
  logic       ecnt3, waitdone, locked, bolt_open, pen_act;
  logic [1:0] err_count;

  logic       rst2, clrtimer2;
  logic       ecnt3_2, waitdone2, locked2, bolt2, pen_act2;
  logic [1:0] err_count2;

  int n_vec = 0;
  int n_err = 0;

  lock_support_ctrl #(.TICK_DIV(1), .MAX_ERR(3), .PENALTY_TICKS(4), .RELOCK_TICKS(3)) dut (
    .clk(clk), .rst(rst), .CLRCNTR(clrcntr), .INC(inc), .CLRTIMER(clrtimer),
    .UNLOCK(unlock), .lock_req(lock_req), .ECNT3(ecnt3), .WAITDONE(waitdone),
    .LOCKED(locked), .bolt_open(bolt_open), .penalty_active(pen_act), .err_count(err_count)
  );

  lock_support_ctrl #(.TICK_DIV(4), .MAX_ERR(3), .PENALTY_TICKS(4), .RELOCK_TICKS(3)) dut4 (
    .clk(clk), .rst(rst2), .CLRCNTR(1'b0), .INC(1'b0), .CLRTIMER(clrtimer2),
    .UNLOCK(1'b0), .lock_req(1'b0), .ECNT3(ecnt3_2), .WAITDONE(waitdone2),
    .LOCKED(locked2), .bolt_open(bolt2), .penalty_active(pen_act2), .err_count(err_count2)
  );

  // Reference model: ticks remaining rather than ticks elapsed.
  int m_err, m_pen_left, m_rel_left;
  bit m_wait, m_open, m_pulse;

  task automatic model_edge();
    if (rst) begin
      m_err = 0; m_pen_left = 0; m_rel_left = 0;
      m_wait = 0; m_open = 0; m_pulse = 0;
    end else begin
      if (clrcntr)                m_err = 0;
      else if (inc && m_err < 3)  m_err = m_err + 1;
      if (clrtimer) begin
        m_pen_left = 4; m_wait = 0;
      end else if (m_pen_left > 0) begin
        m_pen_left--;
        if (m_pen_left == 0) m_wait = 1;
      end
      if (m_pulse) begin
        m_pulse = 0;
      end else if (unlock) begin
        m_open = 1; m_rel_left = 3;
      end else if (m_open) begin
        if (lock_req) begin
          m_open = 0; m_pulse = 1;
        end else begin
          m_rel_left--;
          if (m_rel_left == 0) begin m_open = 0; m_pulse = 1; end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; inc = 1; unlock = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({ecnt3, waitdone, locked, bolt_open, pen_act, err_count} !== 7'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got %b want 0", i,
                 {ecnt3, waitdone, locked, bolt_open, pen_act, err_count});
      end
    end
    rst = 0; inc = 0; unlock = 0;
    step();
    n_vec++;
    if ({ecnt3, waitdone, locked, bolt_open, pen_act, err_count} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_release: got %b want 0",
               {ecnt3, waitdone, locked, bolt_open, pen_act, err_count});
    end
  endtask

  task automatic test_err_count();
    for (int i = 1; i <= 5; i++) begin
      inc = 1; step(); inc = 0;
      n_vec++;
      if (err_count !== 2'((i < 3) ? i : 3) || ecnt3 !== (i >= 3)) begin
        n_err++;
        $display("FAIL inc_%0d: got cnt=%0d ecnt3=%b want cnt=%0d ecnt3=%b",
                 i, err_count, ecnt3, (i < 3) ? i : 3, (i >= 3));
      end
      step();
    end
    inc = 1; clrcntr = 1; step(); inc = 0; clrcntr = 0;
    n_vec++;
    if (err_count !== 2'd0 || ecnt3 !== 1'b0) begin
      n_err++;
      $display("FAIL clr_beats_inc: got cnt=%0d ecnt3=%b want 0/0", err_count, ecnt3);
    end
  endtask

  task automatic test_penalty();
    clrtimer = 1; step(); clrtimer = 0;
    for (int k = 0; k < 7; k++) begin
      n_vec++;
      if (pen_act !== (k < 4) || waitdone !== (k >= 4)) begin
        n_err++;
        $display("FAIL penalty_k%0d: got act=%b wd=%b want act=%b wd=%b",
                 k, pen_act, waitdone, (k < 4), (k >= 4));
      end
      step();
    end
    clrtimer = 1; step(); clrtimer = 0;
    n_vec++;
    if (waitdone !== 1'b0 || pen_act !== 1'b1) begin
      n_err++;
      $display("FAIL penalty_restart: got wd=%b act=%b want 0/1", waitdone, pen_act);
    end
    repeat (5) step();
  endtask

  task automatic test_relock();
    unlock = 1; step(); unlock = 0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (bolt_open !== (k < 3) || locked !== (k == 3)) begin
        n_err++;
        $display("FAIL relock_k%0d: got bolt=%b locked=%b want bolt=%b locked=%b",
                 k, bolt_open, locked, (k < 3), (k == 3));
      end
      if (k == 3) unlock = 1;
      step();
    end
    unlock = 0;
    n_vec++;
    if (bolt_open !== 1'b0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL unlock_in_pulse: got bolt=%b locked=%b want 0/0", bolt_open, locked);
    end
  endtask

  task automatic test_back_to_back();
    unlock = 1; step(); unlock = 0;
    step();
    unlock = 1; step(); unlock = 0;
    for (int j = 0; j < 5; j++) begin
      n_vec++;
      if (bolt_open !== (j < 3) || locked !== (j == 3)) begin
        n_err++;
        $display("FAIL restart_j%0d: got bolt=%b locked=%b want bolt=%b locked=%b",
                 j, bolt_open, locked, (j < 3), (j == 3));
      end
      step();
    end
    unlock = 1; step(); unlock = 0;
    step();
    lock_req = 1; step(); lock_req = 0;
    n_vec++;
    if (locked !== 1'b1 || bolt_open !== 1'b0) begin
      n_err++;
      $display("FAIL lock_req_open: got locked=%b bolt=%b want 1/0", locked, bolt_open);
    end
    step();
    lock_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (locked !== 1'b0 || bolt_open !== 1'b0) begin
        n_err++;
        $display("FAIL lock_req_locked%0d: got locked=%b bolt=%b want 0/0", i, locked, bolt_open);
      end
    end
    unlock = 1; step();
    lock_req = 1; step(); unlock = 0; lock_req = 0;
    n_vec++;
    if (bolt_open !== 1'b1 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL unlock_beats_lockreq: got bolt=%b locked=%b want 1/0", bolt_open, locked);
    end
    repeat (4) step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      clrcntr  = ($urandom_range(0, 7) == 0);
      inc      = ($urandom_range(0, 2) == 0);
      clrtimer = ($urandom_range(0, 9) == 0);
      unlock   = ($urandom_range(0, 7) == 0);
      lock_req = ($urandom_range(0, 7) == 0);
      step();
      n_vec++;
      if (err_count !== 2'(m_err) || ecnt3 !== (m_err == 3)) begin
        n_err++;
        $display("FAIL rand_err cyc%0d: got %0d/%b want %0d", i, err_count, ecnt3, m_err);
      end
      n_vec++;
      if (waitdone !== m_wait || pen_act !== (m_pen_left > 0)) begin
        n_err++;
        $display("FAIL rand_pen cyc%0d: got wd=%b act=%b want wd=%b act=%b",
                 i, waitdone, pen_act, m_wait, (m_pen_left > 0));
      end
      n_vec++;
      if (bolt_open !== m_open || locked !== m_pulse) begin
        n_err++;
        $display("FAIL rand_rel cyc%0d: got bolt=%b locked=%b want bolt=%b locked=%b",
                 i, bolt_open, locked, m_open, m_pulse);
      end
    end
    {rst, clrcntr, inc, clrtimer, unlock, lock_req} = '0;
    step();
  endtask

  task automatic test_tickdiv();
    int n;
    rst2 = 0;
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 7)) step();
      clrtimer2 = 1; step(); clrtimer2 = 0;
      n = 0;
      while (!waitdone2 && n < 40) begin step(); n++; end
      n_vec++;
      if (n < 13 || n > 16) begin
        n_err++;
        $display("FAIL tickdiv_latency t%0d: got %0d cycles want 13..16", t, n);
      end
    end
    clrtimer2 = 1; step(); clrtimer2 = 0;
    repeat (5) step();
    rst2 = 1; step(); rst2 = 0;
    for (int i = 0; i < 25; i++) begin
      n_vec++;
      if (waitdone2 !== 1'b0 || pen_act2 !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid_penalty cyc%0d: got wd=%b act=%b want 0/0", i, waitdone2, pen_act2);
      end
      step();
    end
  endtask

  initial begin
    {rst, clrcntr, inc, clrtimer, unlock, lock_req} = 6'b100000;
    rst2 = 1; clrtimer2 = 0;
    m_err = 0; m_pen_left = 0; m_rel_left = 0;
    m_wait = 0; m_open = 0; m_pulse = 0;
    test_reset();
    test_err_count();
    test_penalty();
    test_relock();
    test_back_to_back();
    test_random();
    test_tickdiv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
